// File: rtl/shared_op_scheduler_pkg.sv
// Shared definitions for the shared-operator scheduler: op codes, FSM states, bus slicing.
package shared_op_scheduler_pkg;

  localparam int unsigned MAX_DW    = 64;
  localparam int unsigned MAX_BUS_W = 1024;

  localparam logic [1:0] OP_ADDI = 2'd0;
  localparam logic [1:0] OP_SUBI = 2'd1;
  localparam logic [1:0] OP_MULI = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Extract the dw-bit slice number idx from a packed bus; caller truncates to its width.
  function automatic logic [MAX_DW-1:0] bus_slice(input logic [MAX_BUS_W-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned dw);
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (idx * dw);
    return shifted[MAX_DW-1:0] & ({MAX_DW{1'b1}} >> (MAX_DW - dw));
  endfunction

endpackage

// File: rtl/shared_op_scheduler_rr_pick.sv
// Combinational round-robin finder: first set bit of elig at or after ptr, wrapping.
module shared_op_scheduler_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid_c,
  output logic [$clog2(N)-1:0] idx_c
);

  localparam int unsigned IDX_W = $clog2(N);

  // Walk the ring backwards so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    int k;
    valid_c = 1'b0;
    idx_c   = '0;
    k       = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % int'(N);
      if (elig[k]) begin
        valid_c = 1'b1;
        idx_c   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/shared_op_scheduler.sv
// Folds N_CH identical immediate operators onto one functional unit, served round-robin
// with one operation in flight; each channel has a one-deep operand and result slot.
module shared_op_scheduler
  import shared_op_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CH       = 4,
  parameter string       OP         = "addi",
  parameter int          IMMEDIATE  = 0,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [N_CH-1:0]            req_in,
  input  logic [N_CH-1:0]            ack_in,
  input  logic [DATA_WIDTH*N_CH-1:0] din,
  input  logic [N_CH-1:0]            req_out,
  output logic [N_CH-1:0]            ack_out,
  output logic [DATA_WIDTH*N_CH-1:0] dout,
  output logic                       busy,
  output logic [N_CH-1:0]            grant,
  output logic [31:0]                op_count
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [1:0]  OP_SEL = (OP == "subi") ? OP_SUBI :
                                   (OP == "muli") ? OP_MULI : OP_ADDI;
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

  state_t                  state, state_next;
  logic [N_CH-1:0]         has_in, has_out;
  logic [DATA_WIDTH-1:0]   in_data  [N_CH];
  logic [DATA_WIDTH-1:0]   out_data [N_CH];
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   fu_c;
  logic [IDX_W-1:0]        rr_ptr, gidx, pick_idx_c;
  logic                    pick_valid_c;
  logic [N_CH-1:0]         elig_c;
  logic [CNT_W-1:0]        cnt;

  // A channel competes only when it has an operand and somewhere to put the result.
  assign elig_c = has_in & ~has_out;

  shared_op_scheduler_rr_pick #(.N(N_CH)) u_rr_pick (
    .elig    (elig_c),
    .ptr     (rr_ptr),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  // Shared functional unit; results wrap modulo 2^DATA_WIDTH.
  always_comb begin
    fu_c = op_a + IMM;
    case (OP_SEL)
      OP_SUBI: fu_c = op_a - IMM;
      OP_MULI: fu_c = op_a * IMM;
      default: fu_c = op_a + IMM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pick_valid_c) state_next = ST_BUSY;
      ST_BUSY: if (cnt == '0)    state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Per-channel fetch/delivery slots plus the grant and completion datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_in   <= '0;
      has_in   <= '0;
      has_out  <= '0;
      ack_out  <= '0;
      dout     <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      op_count <= '0;
      rr_ptr   <= '0;
      gidx     <= '0;
      cnt      <= '0;
      op_a     <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        in_data[c]  <= '0;
        out_data[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (ack_in[c] && req_in[c]) begin
          in_data[c] <= DATA_WIDTH'(bus_slice(MAX_BUS_W'(din), c, DATA_WIDTH));
          has_in[c]  <= 1'b1;
          req_in[c]  <= 1'b0;
        end else if (!has_in[c] && !req_in[c]) begin
          req_in[c] <= 1'b1;
        end
        // The ~ack_out term forces an idle cycle between pulses to a greedy consumer.
        if (has_out[c] && req_out[c] && !ack_out[c]) begin
          ack_out[c]                             <= 1'b1;
          dout[c*DATA_WIDTH +: DATA_WIDTH]       <= out_data[c];
          has_out[c]                             <= 1'b0;
        end else begin
          ack_out[c] <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (pick_valid_c) begin
            op_a               <= in_data[pick_idx_c];
            has_in[pick_idx_c] <= 1'b0;
            grant              <= N_CH'(1) << pick_idx_c;
            busy               <= 1'b1;
            cnt                <= CNT_W'(LATENCY - 1);
            rr_ptr             <= IDX_W'((32'(pick_idx_c) + 32'd1) % N_CH);
            gidx               <= pick_idx_c;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            out_data[gidx] <= fu_c;
            has_out[gidx]  <= 1'b1;
            op_count       <= op_count + 32'd1;
            grant          <= '0;
            busy           <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_op_scheduler.sv
// Bench: addi unit (4 ch, imm 2, latency 1) and muli unit (2 ch, 8 bit, imm 3, latency 3).
module tb_shared_op_scheduler;

  typedef struct packed { logic [31:0] d; logic [31:0] e; } xa_t;
  typedef struct packed { logic [7:0]  d; logic [7:0]  e; } xb_t;
  typedef struct { int ch; logic [31:0] d; logic [31:0] e; } vec_a_t;
  typedef struct { int ch; logic [7:0]  d; logic [7:0]  e; } vec_b_t;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]   req_in_a, ack_in_a, req_out_a, ack_out_a, grant_a;
  logic [127:0] din_a, dout_a;
  logic         busy_a;
  logic [31:0]  op_count_a;

  logic [1:0]   req_in_b, ack_in_b, req_out_b, ack_out_b, grant_b;
  logic [15:0]  din_b, dout_b;
  logic         busy_b;
  logic [31:0]  op_count_b;

  shared_op_scheduler #(.DATA_WIDTH(32), .N_CH(4), .OP("addi"), .IMMEDIATE(2), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_in_a), .ack_in(ack_in_a), .din(din_a),
    .req_out(req_out_a), .ack_out(ack_out_a), .dout(dout_a), .busy(busy_a),
    .grant(grant_a), .op_count(op_count_a));

  shared_op_scheduler #(.DATA_WIDTH(8), .N_CH(2), .OP("muli"), .IMMEDIATE(3), .LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_in_b), .ack_in(ack_in_b), .din(din_b),
    .req_out(req_out_b), .ack_out(ack_out_b), .dout(dout_b), .busy(busy_b),
    .grant(grant_b), .op_count(op_count_b));

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  xa_t         prod_a [4][$];
  logic [31:0] exp_a  [4][$];
  xb_t         prod_b [2][$];
  logic [7:0]  exp_b  [2][$];

  logic [3:0] prev_ack_a, prev_grant_a, rot_exp;
  logic [1:0] prev_ack_b;
  int         gmode, g1_cnt;

  vec_a_t tab_a [5];
  vec_b_t tab_b [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic service_a();
    logic [31:0] e;
    xa_t x;
    for (int c = 0; c < 4; c++) begin
      if (ack_out_a[c]) begin
        chk($sformatf("a_ack_gap%0d", c), 64'(prev_ack_a[c]), 64'd0);
        chk($sformatf("a_ack_req%0d", c), 64'(req_out_a[c]), 64'd1);
        if (exp_a[c].size() == 0) begin
          chk($sformatf("a_unexpected_ack%0d", c), 64'(ack_out_a[c]), 64'd0);
        end else begin
          e = exp_a[c].pop_front();
          chk($sformatf("a_dout%0d", c), 64'(dout_a[c*32 +: 32]), 64'(e));
        end
      end
    end
    prev_ack_a = ack_out_a;
    if (grant_a != 4'd0 && prev_grant_a == 4'd0) begin
      chk("a_grant_onehot", 64'($countones(grant_a)), 64'd1);
      case (gmode)
        1: chk("a_grant_single", 64'(grant_a), 64'd1);
        2: begin
          chk("a_grant_rot", 64'(grant_a), 64'(rot_exp));
          rot_exp = {rot_exp[2:0], rot_exp[3]};
        end
        3: if (grant_a[1]) g1_cnt++;
        default: ;
      endcase
    end
    prev_grant_a = grant_a;
    for (int c = 0; c < 4; c++) begin
      if (req_in_a[c] && !ack_in_a[c] && prod_a[c].size() != 0) begin
        x = prod_a[c].pop_front();
        din_a[c*32 +: 32] = x.d;
        ack_in_a[c] = 1'b1;
        exp_a[c].push_back(x.e);
      end else begin
        ack_in_a[c] = 1'b0;
      end
    end
  endtask

  task automatic service_b();
    logic [7:0] e;
    xb_t x;
    for (int c = 0; c < 2; c++) begin
      if (ack_out_b[c]) begin
        chk($sformatf("b_ack_gap%0d", c), 64'(prev_ack_b[c]), 64'd0);
        if (exp_b[c].size() == 0) begin
          chk($sformatf("b_unexpected_ack%0d", c), 64'(ack_out_b[c]), 64'd0);
        end else begin
          e = exp_b[c].pop_front();
          chk($sformatf("b_dout%0d", c), 64'(dout_b[c*8 +: 8]), 64'(e));
        end
      end
    end
    prev_ack_b = ack_out_b;
    for (int c = 0; c < 2; c++) begin
      if (req_in_b[c] && !ack_in_b[c] && prod_b[c].size() != 0) begin
        x = prod_b[c].pop_front();
        din_b[c*8 +: 8] = x.d;
        ack_in_b[c] = 1'b1;
        exp_b[c].push_back(x.e);
      end else begin
        ack_in_b[c] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    service_a();
    service_b();
  endtask

  function automatic bit all_empty();
    bit r = 1'b1;
    for (int c = 0; c < 4; c++) if (prod_a[c].size() != 0 || exp_a[c].size() != 0) r = 1'b0;
    for (int c = 0; c < 2; c++) if (prod_b[c].size() != 0 || exp_b[c].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (!all_empty() && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 64'(all_empty()), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin prod_a[c].delete(); exp_a[c].delete(); end
    for (int c = 0; c < 2; c++) begin prod_b[c].delete(); exp_b[c].delete(); end
    ack_in_a = '0;
    ack_in_b = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    int n, lat, busy_n;
    rst = 1'b0;
    ack_in_a = '0; din_a = '0; req_out_a = 4'hF;
    ack_in_b = '0; din_b = '0; req_out_b = 2'h3;
    prev_ack_a = '0; prev_grant_a = '0; prev_ack_b = '0;
    rot_exp = 4'b0001; gmode = 0; g1_cnt = 0;

    tab_a[0] = '{0, 32'd0, 32'd2};
    tab_a[1] = '{0, 32'd1, 32'd3};
    tab_a[2] = '{0, 32'd2, 32'd4};
    tab_a[3] = '{0, 32'hFFFF_FFFF, 32'd1};
    tab_a[4] = '{0, 32'hFFFF_FFFE, 32'd0};
    tab_b[0] = '{0, 8'h90, 8'hB0};
    tab_b[1] = '{1, 8'h00, 8'h00};
    tab_b[2] = '{0, 8'h01, 8'h03};
    tab_b[3] = '{1, 8'hFF, 8'hFD};
    tab_b[4] = '{0, 8'h55, 8'hFF};
    tab_b[5] = '{1, 8'h56, 8'h02};

    // Reset state
    repeat (3) tick();
    chk("rst_req_in",   64'(req_in_a), 64'd0);
    chk("rst_ack_out",  64'(ack_out_a), 64'd0);
    chk("rst_dout",     64'(dout_a != '0), 64'd0);
    chk("rst_grant",    64'(grant_a), 64'd0);
    chk("rst_busy",     64'(busy_a), 64'd0);
    chk("rst_op_count", 64'(op_count_a), 64'd0);
    chk("rst_b_busy",   64'(busy_b), 64'd0);
    rst = 1'b1;

    // Single channel: only grant 0001, in-order results, wrap at the top of the range
    gmode = 1;
    for (int i = 0; i < 5; i++) prod_a[tab_a[i].ch].push_back('{tab_a[i].d, tab_a[i].e});
    drain("single");
    chk("single_op_count", 64'(op_count_a), 64'd5);

    // All four producers streaming: strict rotation starting at channel 0
    do_reset();
    gmode = 2; rot_exp = 4'b0001;
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++)
        prod_a[c].push_back('{32'(10*c + k), 32'(10*c + k + 2)});
    drain("rotate");
    chk("rotate_op_count", 64'(op_count_a), 64'd20);

    // Consumer 1 stalls for 50 cycles: one grant, then skipped until it drains
    do_reset();
    gmode = 3; g1_cnt = 0; req_out_a = 4'b1101;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        prod_a[c].push_back('{32'(100*c + k), 32'(100*c + k + 2)});
    repeat (50) tick();
    chk("stall_ch1_grants", 64'(g1_cnt), 64'd1);
    chk("stall_ch1_pending", 64'(exp_a[1].size()), 64'd2);
    req_out_a = 4'hF;
    drain("stall");
    chk("stall_ch1_total", 64'(g1_cnt), 64'd4);
    chk("stall_op_count", 64'(op_count_a), 64'd16);
    gmode = 0;

    // Latency 3: busy exactly 3 cycles, ack 4 edges after the grant edge
    do_reset();
    prod_b[0].push_back('{8'h05, 8'h0F});
    n = 0;
    while (busy_b !== 1'b1 && n < 30) begin tick(); n++; end
    chk("lat_busy_seen", 64'(busy_b), 64'd1);
    lat = 0; busy_n = 1;
    while (ack_out_b[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (busy_b) busy_n++;
    end
    chk("lat_ack_edges", 64'(lat), 64'd4);
    chk("lat_busy_cycles", 64'(busy_n), 64'd3);
    drain("lat");

    // muli table with 8-bit truncation
    for (int i = 0; i < 6; i++) prod_b[tab_b[i].ch].push_back('{tab_b[i].d, tab_b[i].e});
    drain("muli");
    chk("muli_op_count", 64'(op_count_b), 64'd7);

    // Reset mid-operation discards the in-flight op and clears the counter
    prod_b[1].push_back('{8'h10, 8'h30});
    prod_a[2].push_back('{32'd7, 32'd9});
    n = 0;
    while (busy_b !== 1'b1 && n < 30) begin tick(); n++; end
    chk("midrst_busy_seen", 64'(busy_b), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy_b",  64'(busy_b), 64'd0);
    chk("midrst_grant_b", 64'(grant_b), 64'd0);
    chk("midrst_opcnt_b", 64'(op_count_b), 64'd0);
    chk("midrst_req_in",  64'({req_in_a, req_in_b}), 64'd0);
    chk("midrst_opcnt_a", 64'(op_count_a), 64'd0);
    chk("midrst_dout",    64'((dout_a != '0) || (dout_b != '0)), 64'd0);
    do_reset();
    prod_b[1].push_back('{8'h04, 8'h0C});
    drain("post_rst");
    chk("post_rst_opcnt_b", 64'(op_count_b), 64'd1);
    chk("post_rst_opcnt_a", 64'(op_count_a), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
